// File: rtl/player_input_ctrl.sv
// Per-player joystick front end: 2-flop sync, debounce, priority encode, event/overrun flags.
// Define PLAYER_INPUT_HOLD_EN to hold the last direction when all switches are released.
module player_input_ctrl #(
    parameter int unsigned N_PLAYERS       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*N_PLAYERS-1:0] dir_sw,
    input  logic [N_PLAYERS-1:0]   dir_ack,
    output logic [3*N_PLAYERS-1:0] dir_out,
    output logic [N_PLAYERS-1:0]   dir_pend,
    output logic [N_PLAYERS-1:0]   dir_ovr
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
        logic [3:0]       sync1, sync2, sync_prev, stable;
        logic [CNT_W-1:0] cnt, cnt_eff;
        logic [2:0]       enc, out_q;
        logic             load, evt;
        logic             pend_q, ovr_q;

        // A fresh change in the synchronised value restarts the count from zero
        always_comb begin
            cnt_eff = (sync2 != sync_prev) ? '0 : cnt;
            enc     = 3'b000;
            if (stable[0])      enc = 3'b100;
            else if (stable[1]) enc = 3'b101;
            else if (stable[2]) enc = 3'b110;
            else if (stable[3]) enc = 3'b111;
`ifdef PLAYER_INPUT_HOLD_EN
            load = enc[2];
`else
            load = 1'b1;
`endif
            evt = load && (enc != out_q);
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1     <= '0;
                sync2     <= '0;
                sync_prev <= '0;
                stable    <= '0;
                cnt       <= '0;
                out_q     <= '0;
                pend_q    <= 1'b0;
                ovr_q     <= 1'b0;
            end else begin
                sync1     <= dir_sw[4*i +: 4];
                sync2     <= sync1;
                sync_prev <= sync2;

                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt_eff == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_eff + CNT_W'(1);
                end

                if (evt) out_q <= enc;

                // Ack coinciding with an event keeps pend but forgives the overrun
                if (evt) begin
                    pend_q <= 1'b1;
                    if (dir_ack[i])  ovr_q <= 1'b0;
                    else if (pend_q) ovr_q <= 1'b1;
                end else if (dir_ack[i]) begin
                    pend_q <= 1'b0;
                    ovr_q  <= 1'b0;
                end
            end
        end

        assign dir_out[3*i +: 3] = out_q;
        assign dir_pend[i]       = pend_q;
        assign dir_ovr[i]        = ovr_q;
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed scoreboard bench for player_input_ctrl (N_PLAYERS=2, DEBOUNCE_CYCLES=4).
module tb_player_input_ctrl;

`ifdef PLAYER_INPUT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [9:0]  exp;
    } sb_entry_t;

    logic       clock;
    logic       reset;
    logic [7:0] dir_sw;
    logic [1:0] dir_ack;
    logic [5:0] dir_out;
    logic [1:0] dir_pend;
    logic [1:0] dir_ovr;

    int unsigned cyc;
    int          checks;
    int          passed;
    sb_entry_t   sb[$];

    player_input_ctrl #(.N_PLAYERS(2), .DEBOUNCE_CYCLES(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .dir_sw  (dir_sw),
        .dir_ack (dir_ack),
        .dir_out (dir_out),
        .dir_pend(dir_pend),
        .dir_ovr (dir_ovr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    function automatic logic [9:0] mk(input logic [1:0] ovr, input logic [1:0] pend,
                                      input logic [2:0] o1, input logic [2:0] o0);
        return {ovr, pend, o1, o0};
    endfunction

    task automatic push(input int unsigned c, input string tag, input logic [9:0] exp);
        sb_entry_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int unsigned n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Compare every entry due this cycle; overdue entries count as failures
    always @(negedge clock) begin
        logic [9:0] obs;
        obs = {dir_ovr, dir_pend, dir_out};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                assert (obs === sb[i].exp) passed++;
                else $error("FAIL %s @%0d: observed {ovr,pend,out}=%b expected %b",
                            sb[i].tag, cyc, obs, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                assert (sb[i].cyc >= cyc) passed++;
                else $error("FAIL %s: check at cycle %0d never reached, observed %b expected %b",
                            sb[i].tag, sb[i].cyc, obs, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        logic [2:0] rel_out;
        logic [1:0] rel_pend;
        cyc     = 0;
        checks  = 0;
        passed  = 0;
        reset   = 1'b1;
        dir_sw  = '0;
        dir_ack = '0;
        rel_out  = HOLD ? 3'b111 : 3'b000;
        rel_pend = HOLD ? 2'b00 : 2'b01;

        wait_to(2);
        push(2, "reset_state", mk(2'b00, 2'b00, 3'b000, 3'b000));
        reset       = 1'b0;
        dir_sw[3:0] = 4'b0001;
        push(8,  "p0_up_early",  mk(2'b00, 2'b00, 3'b000, 3'b000));
        push(9,  "p0_up_accept", mk(2'b00, 2'b01, 3'b000, 3'b100));

        wait_to(11);
        dir_ack = 2'b01;
        push(11, "p0_pend_pre_ack", mk(2'b00, 2'b01, 3'b000, 3'b100));
        wait_to(12);
        dir_ack = 2'b00;
        push(12, "p0_ack_clear", mk(2'b00, 2'b00, 3'b000, 3'b100));

        dir_sw[7:4] = 4'b0010;
        wait_to(15);
        dir_sw[7:4] = 4'b0000;
        push(18, "p1_glitch",      mk(2'b00, 2'b00, 3'b000, 3'b100));
        push(22, "p1_glitch_late", mk(2'b00, 2'b00, 3'b000, 3'b100));

        wait_to(16);
        dir_sw[3:0] = 4'b1001;
        push(24, "p0_up_left_prio", mk(2'b00, 2'b00, 3'b000, 3'b100));

        wait_to(24);
        dir_sw[3:0] = 4'b1000;
        push(31, "p0_left", mk(2'b00, 2'b01, 3'b000, 3'b111));
        wait_to(32);
        dir_ack = 2'b01;
        wait_to(33);
        dir_ack     = 2'b00;
        dir_sw[3:0] = 4'b0001;
        push(33, "p0_left_ack", mk(2'b00, 2'b00, 3'b000, 3'b111));
        push(40, "p0_up_again", mk(2'b00, 2'b01, 3'b000, 3'b100));

        wait_to(40);
        dir_sw[3:0] = 4'b0100;
        push(46, "p0_down_pre",   mk(2'b00, 2'b01, 3'b000, 3'b100));
        push(47, "p0_overrun",    mk(2'b01, 2'b01, 3'b000, 3'b110));
        push(48, "p0_ovr_sticky", mk(2'b01, 2'b01, 3'b000, 3'b110));
        wait_to(48);
        dir_ack = 2'b01;
        wait_to(49);
        dir_ack = 2'b00;
        push(49, "p0_ovr_ack", mk(2'b00, 2'b00, 3'b000, 3'b110));

        dir_sw[3:0] = 4'b1000;
        push(56, "p0_left2", mk(2'b00, 2'b01, 3'b000, 3'b111));
        wait_to(57);
        dir_ack = 2'b01;
        wait_to(58);
        dir_ack     = 2'b00;
        dir_sw[3:0] = 4'b0000;
        push(58, "p0_left2_ack", mk(2'b00, 2'b00, 3'b000, 3'b111));
        push(64, "p0_release_pre", mk(2'b00, 2'b00, 3'b000, 3'b111));
        push(65, "p0_release", mk(2'b00, rel_pend, 3'b000, rel_out));
        wait_to(66);
        dir_ack = 2'b01;
        wait_to(67);
        dir_ack = 2'b00;
        push(67, "p0_release_ack", mk(2'b00, 2'b00, 3'b000, rel_out));

        dir_sw[7:4] = 4'b0010;
        push(74, "p1_right", mk(2'b00, 2'b10, 3'b101, rel_out));
        wait_to(74);
        dir_sw[3:0] = 4'b0001;
        wait_to(77);
        reset = 1'b1;
        push(77, "reset_async", mk(2'b00, 2'b00, 3'b000, 3'b000));
        wait_to(79);
        reset = 1'b0;
        push(85, "post_reset_early", mk(2'b00, 2'b00, 3'b000, 3'b000));
        push(86, "post_reset_both",  mk(2'b00, 2'b11, 3'b101, 3'b100));

        wait_to(86);
        dir_sw[3:0] = 4'b0010;
        push(93, "p0_ovr_again", mk(2'b01, 2'b11, 3'b101, 3'b101));
        wait_to(93);
        dir_sw[3:0] = 4'b0100;
        push(99, "pre_coincide", mk(2'b01, 2'b11, 3'b101, 3'b101));
        wait_to(99);
        dir_ack = 2'b01;
        wait_to(100);
        dir_ack = 2'b00;
        push(100, "ack_event_coincide", mk(2'b00, 2'b11, 3'b101, 3'b110));
        wait_to(101);
        dir_ack = 2'b11;
        wait_to(102);
        dir_ack = 2'b00;
        push(102, "final_ack_both", mk(2'b00, 2'b00, 3'b101, 3'b110));

        wait_to(105);
        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL %0d scoreboard entries left unchecked", sb.size());
        checks++;
        assert ({dir_ovr, dir_pend, dir_out} === mk(2'b00, 2'b00, 3'b101, 3'b110)) passed++;
        else $error("FAIL final_state: observed %b", {dir_ovr, dir_pend, dir_out});
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
